// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op bit indices,
// FSM state encoding and small arithmetic helpers.
package muldiv_seq_pkg;

    localparam int MD_WIDTH = 32;

    // op is one-hot, ordered {MULT, MULTU, DIV, DIVU, MTHI, MTLO}
    localparam int MD_MULT  = 5;
    localparam int MD_MULTU = 4;
    localparam int MD_DIV   = 3;
    localparam int MD_DIVU  = 2;
    localparam int MD_MTHI  = 1;
    localparam int MD_MTLO  = 0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_MUL  = 3'd2,
        ST_DIV  = 3'd3,
        ST_FIX  = 3'd4
    } md_state_e;

    function automatic logic op_onehot(input logic [5:0] v);
        return (v != 6'd0) && ((v & (v - 6'd1)) == 6'd0);
    endfunction

    function automatic logic [MD_WIDTH-1:0] cond_neg(input logic [MD_WIDTH-1:0] v,
                                                    input logic take);
        return take ? (~v + MD_WIDTH'(1)) : v;
    endfunction

endpackage

// File: rtl/muldiv_seq_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module muldiv_seq_div_step (
    input  logic [31:0] rem,
    input  logic [31:0] quo,
    input  logic [31:0] divisor,
    output logic [31:0] rem_next,
    output logic [31:0] quo_next
);
    logic [32:0] part;
    logic        fits;
    logic [31:0] diff;

    // The partial remainder is kept 33 bits wide so divisors above 2^31 work.
    assign part     = {rem, quo[31]};
    assign fits     = (part >= {1'b0, divisor});
    assign diff     = part[31:0] - divisor;
    assign rem_next = fits ? diff : part[31:0];
    assign quo_next = {quo[30:0], fits};

endmodule

// File: rtl/muldiv_seq.sv
// HI/LO unit for the EX stage: single-cycle MTHI/MTLO, fixed-latency
// multiply and an iterative restoring divider, all committing to HI/LO.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int DIV_ITERS   = 32,
    parameter int MUL_LATENCY = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_valid,
    input  logic [5:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        op_ready,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_by_zero
);
    localparam int               CNT_W    = $clog2(DIV_ITERS);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_ITERS - 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LATENCY - 1);

    md_state_e          state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        hi_q, lo_q;
    logic               dbz_q;

    logic [31:0]        a_q, b_q;
    logic               signed_q, sq_q, sr_q, dz_q;
    logic [31:0]        rem_q, quo_q, dvs_q;

    logic               accept, is_mul, is_div;
    logic [31:0]        rem_d, quo_d, fix_hi_d, fix_lo_d;
    logic signed [63:0] mul_a, mul_b, prod_d;

    assign is_mul = op[MD_MULT] | op[MD_MULTU];
    assign is_div = op[MD_DIV]  | op[MD_DIVU];
    assign accept = op_valid & (state_q == ST_IDLE) & ~flush & op_onehot(op);

    muldiv_seq_div_step u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvs_q),
        .rem_next (rem_d),
        .quo_next (quo_d)
    );

    // Low 64 bits of the product of sign- or zero-extended operands.
    assign mul_a  = {{32{signed_q & a_q[31]}}, a_q};
    assign mul_b  = {{32{signed_q & b_q[31]}}, b_q};
    assign prod_d = mul_a * mul_b;

    assign fix_lo_d = dz_q ? 32'hFFFF_FFFF : cond_neg(quo_q, sq_q);
    assign fix_hi_d = dz_q ? a_q           : cond_neg(rem_q, sr_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
        end else begin
            dbz_q <= 1'b0;
            if (state_q != ST_IDLE && flush) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (accept) begin
                            if (op[MD_MTHI]) hi_q <= a;
                            if (op[MD_MTLO]) lo_q <= a;
                            if (is_mul) begin
                                state_q <= ST_MUL;
                                cnt_q   <= '0;
                            end
                            if (is_div) state_q <= ST_PREP;
                        end
                    end
                    ST_PREP: begin
                        cnt_q   <= '0;
                        state_q <= (b_q == 32'd0) ? ST_FIX : ST_DIV;
                    end
                    ST_MUL: begin
                        if (cnt_q == MUL_LAST) begin
                            {hi_q, lo_q} <= prod_d;
                            state_q      <= ST_IDLE;
                            cnt_q        <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ST_DIV: begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == DIV_LAST) state_q <= ST_FIX;
                    end
                    ST_FIX: begin
                        hi_q    <= fix_hi_d;
                        lo_q    <= fix_lo_d;
                        dbz_q   <= dz_q;
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    // Datapath registers carry no reset; the FSM decides when they are meaningful.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q      <= a;
            b_q      <= b;
            signed_q <= op[MD_MULT] | op[MD_DIV];
        end
        if (state_q == ST_PREP) begin
            rem_q <= '0;
            quo_q <= cond_neg(a_q, signed_q & a_q[31]);
            dvs_q <= cond_neg(b_q, signed_q & b_q[31]);
            sq_q  <= signed_q & (a_q[31] ^ b_q[31]);
            sr_q  <= signed_q & a_q[31];
            dz_q  <= (b_q == 32'd0);
        end else if (state_q == ST_DIV) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
        end
    end

    assign op_ready    = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule
